nibble_serial_tx: RTL and testbench

//  Reader/transmitter end of the 4-bit register path: captures a parallel word
//  on a start strobe and shifts it out serially, MSB first, one bit per clock.

---
 rtl/nibble_serial_tx_pkg.sv | 13 +
 rtl/nibble_serial_tx_ffd_en_reg.sv | 20 ++
 rtl/nibble_serial_tx.sv | 98 +++++++++
 tb/tb_nibble_serial_tx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_tx_pkg.sv
// Shared types and constants for the nibble serial transmitter and its matching receiver.
// State encodings are fixed (IDLE=00, SHIFT=01, FIN=10) so both ends stay in step.
package nibble_serial_tx_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_FIN   = 2'b10
   } state_t;

   localparam logic NST_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/nibble_serial_tx_ffd_en_reg.sv
// WIDTH-bit D register with synchronous active-high reset and load enable.
// Latency 1 clock from en to q; no backpressure.
module ffd_en_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/nibble_serial_tx.sv
// Captures D on a start strobe and shifts it out MSB first; optional even parity bit (NIBBLE_SERIAL_TX_PARITY_EN).
// First bit 1 clock after ST is sampled; starts arriving while busy or finishing are dropped.
module nibble_serial_tx
   import nibble_serial_tx_pkg::*;
#(
   parameter int   WIDTH      = 4,
   parameter logic IDLE_LEVEL = NST_IDLE_LEVEL
) (
   input  logic             clock,
   input  logic             RST,
   input  logic             ST,
   input  logic [WIDTH-1:0] D,
   output logic             SO,
   output logic             BUSY,
   output logic             DONE
);

`ifdef NIBBLE_SERIAL_TX_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int CW = $clog2(FRAME + 1);

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n, nxt_idx;
   logic             so_n, busy_n, done_n, load;
   logic [WIDTH-1:0] word;
   logic [FRAME-1:0] frame_bits, frame_shift;

   ffd_en_reg #(.WIDTH(WIDTH)) u_word (
      .clk (clock),
      .rst (RST),
      .en  (load),
      .d   (D),
      .q   (word)
   );

`ifdef NIBBLE_SERIAL_TX_PARITY_EN
   assign frame_bits = {word, ^word};
`else
   assign frame_bits = word;
`endif

   // Left-shifting the frame by the next index puts the next bit at the MSB.
   assign nxt_idx     = cnt + CW'(1);
   assign frame_shift = frame_bits << nxt_idx;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      so_n    = IDLE_LEVEL;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      load    = 1'b0;
      case (state)
         S_IDLE: begin
            if (ST) begin
               load    = 1'b1;
               state_n = S_SHIFT;
               cnt_n   = '0;
               so_n    = D[WIDTH-1];
               busy_n  = 1'b1;
            end
         end
         S_SHIFT: begin
            if (cnt == CW'(FRAME - 1)) begin
               state_n = S_FIN;
               cnt_n   = '0;
               done_n  = 1'b1;
            end else begin
               cnt_n  = nxt_idx;
               so_n   = frame_shift[FRAME-1];
               busy_n = 1'b1;
            end
         end
         S_FIN:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (RST) begin
         state <= S_IDLE;
         cnt   <= '0;
         SO    <= IDLE_LEVEL;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         SO    <= so_n;
         BUSY  <= busy_n;
         DONE  <= done_n;
      end
   end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Directed bench for nibble_serial_tx: reset, single frames, ignored start, abort, back-to-back, parity.
module tb_nibble_serial_tx;

   localparam int WIDTH = 4;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif

   logic             clock = 1'b0;
   logic             RST, ST;
   logic [WIDTH-1:0] D;
   logic             SO, BUSY, DONE;

   int n_checks = 0;
   int n_fail   = 0;

   nibble_serial_tx #(.WIDTH(WIDTH)) dut (
      .clock (clock),
      .RST   (RST),
      .ST    (ST),
      .D     (D),
      .SO    (SO),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Sends one frame and checks every bit, the DONE pulse and the idle that follows.
   // inj >= 0 raises ST with a different word during bit inj (must be ignored).
   task automatic run_frame(input logic [FRAME-1:0] exp_bits, input logic [WIDTH-1:0] d,
                            input int inj);
      logic [FRAME-1:0] sh;
      sh = exp_bits;
      ST = 1'b1;
      D  = d;
      tick();
      ST = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         check("frame_so", SO, sh[FRAME-1]);
         check("frame_busy", BUSY, 1'b1);
         check("frame_done", DONE, 1'b0);
         sh = sh << 1;
         if (i == inj) begin
            ST = 1'b1;
            D  = 4'b0110;
         end else begin
            ST = 1'b0;
         end
         tick();
      end
      ST = 1'b0;
      check("fin_done", DONE, 1'b1);
      check("fin_busy", BUSY, 1'b0);
      check("fin_so", SO, 1'b0);
      tick();
      check("idle_done", DONE, 1'b0);
      check("idle_busy", BUSY, 1'b0);
      tick();
      check("no_restart_busy", BUSY, 1'b0);
      check("no_restart_so", SO, 1'b0);
   endtask

   initial begin
      logic             seen_done;
      logic [FRAME-1:0] exp;

      // Reset held with a pending start: nothing may leave the block.
      RST = 1'b1;
      ST  = 1'b1;
      D   = 4'b1100;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_so", SO, 1'b0);
         check("rst_busy", BUSY, 1'b0);
         check("rst_done", DONE, 1'b0);
      end
      RST = 1'b0;
      ST  = 1'b0;
      tick();
      tick();
      check("post_rst_busy", BUSY, 1'b0);
      check("post_rst_so", SO, 1'b0);

      // Plain frame of 1011, then the same frame with a start injected mid-frame.
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
      exp = 5'b10111;
`else
      exp = 4'b1011;
`endif
      run_frame(exp, 4'b1011, -1);
      run_frame(exp, 4'b1011, 1);

      // Abort after the second bit of 1110.
      ST = 1'b1;
      D  = 4'b1110;
      tick();
      ST = 1'b0;
      check("abort_b0", SO, 1'b1);
      check("abort_busy0", BUSY, 1'b1);
      tick();
      check("abort_b1", SO, 1'b1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("abort_so", SO, 1'b0);
      check("abort_busy", BUSY, 1'b0);
      check("abort_done", DONE, 1'b0);
      seen_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen_done = seen_done | DONE | BUSY;
      end
      check("abort_quiet", seen_done, 1'b0);

      // Back-to-back frames of 0101 with ST held high.
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
      exp = 5'b01010;
`else
      exp = 4'b0101;
`endif
      ST = 1'b1;
      D  = 4'b0101;
      tick();
      for (int f = 0; f < 3; f++) begin
         logic [FRAME-1:0] sh;
         sh = exp;
         for (int i = 0; i < FRAME; i++) begin
            check("b2b_so", SO, sh[FRAME-1]);
            check("b2b_busy", BUSY, 1'b1);
            check("b2b_done", DONE, 1'b0);
            sh = sh << 1;
            tick();
         end
         check("b2b_fin_done", DONE, 1'b1);
         check("b2b_fin_busy", BUSY, 1'b0);
         tick();
         check("b2b_idle_done", DONE, 1'b0);
         check("b2b_idle_busy", BUSY, 1'b0);
         if (f == 2) ST = 1'b0;
         tick();
      end
      check("b2b_stop_busy", BUSY, 1'b0);
      tick();

`ifdef NIBBLE_SERIAL_TX_PARITY_EN
      run_frame(5'b01111, 4'b0111, -1);
      run_frame(5'b00110, 4'b0011, -1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
